mem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-ported, synchronous-read program/data `memory`. It shares the memory between the processor's instruction-fetch path and its load/store path. Each access runs as a fixed four-state transaction. Word-misaligned and out-of-range addresses are rejected without touching memory.

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: processor fetch/data ports and memory port of mem_arbiter.
// slave is the arbiter side; master is the processor + memory side.
interface mem_arbiter_if;
  logic        iFReq;
  logic [31:0] iFAddr;
  logic        oFDone;
  logic        oFErr;
  logic [31:0] oFData;
  logic        iDReq;
  logic        iDWrite;
  logic [31:0] iDAddr;
  logic [31:0] iDData;
  logic        oDDone;
  logic        oDErr;
  logic [31:0] oDData;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic [31:0] iMemData;

  modport slave (
    input  iFReq, iFAddr, iDReq, iDWrite, iDAddr, iDData, iMemData,
    output oFDone, oFErr, oFData, oDDone, oDErr, oDData,
    output oMemRead, oMemWrite, oMemAddr, oMemData
  );

  modport master (
    output iFReq, iFAddr, iDReq, iDWrite, iDAddr, iDData, iMemData,
    input  oFDone, oFErr, oFData, oDDone, oDErr, oDData,
    input  oMemRead, oMemWrite, oMemAddr, oMemData
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter + IDLE/ISSUE/CAPTURE/DONE memory sequencer.
// Define MEM_ARB_RR_EN for round-robin grant; default gives data priority.
module mem_arbiter #(
  parameter int MEM_WORDS = 1024
) (
  input logic          iClk,
  input logic          nRst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, CAPTURE, DONE
  } state_t;

  localparam logic [32:0] LIMIT = 33'(4 * MEM_WORDS);

  state_t      r_state, w_state;
  logic        r_sel, w_sel;
  logic        r_we, w_we;
  logic        r_err, w_err;
  logic        r_mrd, w_mrd;
  logic        r_mwr, w_mwr;
  logic [31:0] r_maddr, w_maddr;
  logic [31:0] r_mdata, w_mdata;
  logic        r_fdone, w_fdone;
  logic        r_ferr, w_ferr;
  logic [31:0] r_fdata, w_fdata;
  logic        r_ddone, w_ddone;
  logic        r_derr, w_derr;
  logic [31:0] r_ddata, w_ddata;
  logic        w_gnt_d;
  logic        w_st;
  logic        w_ok;
  logic [31:0] w_addr;
  logic [31:0] w_cap;

`ifdef MEM_ARB_RR_EN
  logic r_last, w_last;
  // r_last: 1 = data granted last, 0 = fetch
  assign w_gnt_d = bus.iDReq & (~bus.iFReq | ~r_last);
`else
  assign w_gnt_d = bus.iDReq;
`endif

  assign w_addr = w_gnt_d ? bus.iDAddr : bus.iFAddr;
  assign w_st   = w_gnt_d & bus.iDWrite;
  assign w_ok   = (w_addr[1:0] == 2'b00) && ({1'b0, w_addr} < LIMIT);
  assign w_cap  = (r_err | r_we) ? 32'h0 : bus.iMemData;

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_we    = r_we;
    w_err   = r_err;
    w_mrd   = 1'b0;
    w_mwr   = 1'b0;
    w_maddr = r_maddr;
    w_mdata = r_mdata;
    w_fdone = 1'b0;
    w_ferr  = 1'b0;
    w_fdata = r_fdata;
    w_ddone = 1'b0;
    w_derr  = 1'b0;
    w_ddata = r_ddata;
`ifdef MEM_ARB_RR_EN
    w_last  = r_last;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.iFReq | bus.iDReq) begin
          w_sel = w_gnt_d;
          w_we  = w_st;
          w_err = ~w_ok;
`ifdef MEM_ARB_RR_EN
          w_last = w_gnt_d;
`endif
          if (w_ok) begin
            w_state = ISSUE;
            w_maddr = w_addr;
            w_mdata = w_st ? bus.iDData : 32'h0;
            w_mrd   = ~w_st;
            w_mwr   = w_st;
          end else begin
            // rejected: no strobe, still one cycle before Done
            w_state = CAPTURE;
          end
        end
      end
      ISSUE: w_state = CAPTURE;
      CAPTURE: begin
        w_state = DONE;
        if (r_sel) begin
          w_ddone = 1'b1;
          w_derr  = r_err;
          w_ddata = w_cap;
        end else begin
          w_fdone = 1'b1;
          w_ferr  = r_err;
          w_fdata = w_cap;
        end
      end
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_maddr <= 32'h0;
      r_mdata <= 32'h0;
      r_fdone <= 1'b0;
      r_ferr  <= 1'b0;
      r_fdata <= 32'h0;
      r_ddone <= 1'b0;
      r_derr  <= 1'b0;
      r_ddata <= 32'h0;
`ifdef MEM_ARB_RR_EN
      r_last  <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_we    <= w_we;
      r_err   <= w_err;
      r_mrd   <= w_mrd;
      r_mwr   <= w_mwr;
      r_maddr <= w_maddr;
      r_mdata <= w_mdata;
      r_fdone <= w_fdone;
      r_ferr  <= w_ferr;
      r_fdata <= w_fdata;
      r_ddone <= w_ddone;
      r_derr  <= w_derr;
      r_ddata <= w_ddata;
`ifdef MEM_ARB_RR_EN
      r_last  <= w_last;
`endif
    end
  end

  assign bus.oFDone    = r_fdone;
  assign bus.oFErr     = r_ferr;
  assign bus.oFData    = r_fdata;
  assign bus.oDDone    = r_ddone;
  assign bus.oDErr     = r_derr;
  assign bus.oDData    = r_ddata;
  assign bus.oMemRead  = r_mrd;
  assign bus.oMemWrite = r_mwr;
  assign bus.oMemAddr  = r_maddr;
  assign bus.oMemData  = r_mdata;
endmodule
